kernel_cc_write_back_start_ctrl: RTL

KERNEL_CC_WRITE_BACK_START_CTRL -- requirements
Module: kernel_cc_write_back_start_ctrl

---
 rtl/kernel_cc_write_back_start_ctrl.sv | 78 +++++++
 1 files changed

// File: rtl/kernel_cc_write_back_start_ctrl.sv
// rtl/kernel_cc_write_back_start_ctrl.sv - start-FIFO to write_back task start controller with inflight cap
module kernel_cc_write_back_start_ctrl #(
    parameter int DATA_WIDTH   = 1,
    parameter int MAX_INFLIGHT = 2,
    parameter int CNT_WIDTH    = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  fifo_empty_n,
    input  logic [DATA_WIDTH-1:0] fifo_dout,
    output logic                  fifo_read,
    output logic                  task_start,
    input  logic                  task_ready,
    input  logic                  task_done,
    output logic [DATA_WIDTH-1:0] token_q,
    output logic [3:0]            inflight,
    output logic [CNT_WIDTH-1:0]  done_count,
    output logic                  ctrl_idle,
    output logic                  err_sticky
);

    localparam logic [3:0] MAX_Q = 4'(MAX_INFLIGHT);

    typedef enum logic {
        IDLE  = 1'b0,
        START = 1'b1
    } state_t;

    state_t state, state_nxt;
    logic   accepted;

    // Outputs are forced low during reset even though state only clears at the edge.
    always_comb begin
        fifo_read  = 1'b0;
        task_start = 1'b0;
        state_nxt  = state;
        if (!reset) begin
            fifo_read  = (state == IDLE) && fifo_empty_n && (inflight < MAX_Q);
            task_start = (state == START);
        end
        case (state)
            IDLE:    if (fifo_read) state_nxt = START;
            START:   if (task_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign accepted  = task_start && task_ready;
    assign ctrl_idle = (state == IDLE) && (inflight == 4'd0);

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            token_q    <= '0;
            inflight   <= 4'd0;
            done_count <= '0;
            err_sticky <= 1'b0;
        end else begin
            state <= state_nxt;
            if (fifo_read) begin
                token_q <= fifo_dout;
            end
            if (accepted && !task_done) begin
                inflight <= inflight + 4'd1;
            end else if (task_done && !accepted) begin
                if (inflight != 4'd0) begin
                    inflight <= inflight - 4'd1;
                end else begin
                    err_sticky <= 1'b1;
                end
            end
            if (task_done) begin
                done_count <= done_count + 1'b1;
            end
        end
    end

endmodule
